// File: rtl/alu_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand width is cut into STAGES slices. Each slice is a block-lookahead
// adder, and a registered carry links one slice to the next. Operand bits that
// have not been summed yet ride forward in skew registers. Result bits that are
// already summed ride forward in deskew registers. A single advance signal
// moves the whole pipe, so backpressure stalls every stage together.

// Block-lookahead slice: group generate/propagate picks the carry into each
// group, and ripple inside a group rebuilds the per-bit carries.
module alu_addsub_cla_slice #(
  parameter int SW    = 8,
  parameter int GROUP = 4
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_c,
  output logic [SW-1:0] o_s,
  output logic          o_c
);
  localparam int NG = SW / GROUP;

  logic [SW-1:0] w_g, w_p, w_c;
  logic [NG-1:0] w_gg, w_gp;
  logic [NG:0]   w_gc;

  // group lookahead terms, then group carries, then bit carries
  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    for (int j = 0; j < NG; j++) begin
      w_gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        w_gg[j] = w_g[j*GROUP+i] | (w_p[j*GROUP+i] & w_gg[j]);
        w_gp[j] = w_gp[j] & w_p[j*GROUP+i];
      end
    end
    w_gc[0] = i_c;
    for (int j = 0; j < NG; j++)
      w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
    for (int i = 0; i < SW; i++) begin
      if ((i % GROUP) == 0) w_c[i] = w_gc[i/GROUP];
      else                  w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
    end
  end

  assign o_s = w_p ^ w_c;
  assign o_c = w_gc[NG];
endmodule

module alu_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_use_cin,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);
  localparam int SW = WIDTH / STAGES;

  logic [WIDTH-1:0]  w_effb;
  logic              w_effc;
  logic              w_adv;
  logic [STAGES-1:0] r_vld_pipe;

  assign w_effb = i_b ^ {WIDTH{i_sub}};
  assign w_effc = i_use_cin ? i_cin : i_sub;
  // The pipe moves as a whole whenever the output slot is free or draining.
  assign w_adv  = !r_vld_pipe[STAGES-1] || i_out_ready;

  // valid shift register; bubbles move along with the data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_vld_pipe <= '0;
    else if (w_adv) begin
      r_vld_pipe[0] <= i_in_valid;
      for (int s = 1; s < STAGES; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SW;
    localparam int REM = WIDTH - LO;  // operand bits not yet summed, this slice included

    logic [REM-1:0]   w_asrc, w_bsrc;
    logic [SW-1:0]    w_ss;
    logic             w_ci, w_zi, w_co;
    logic [LO+SW-1:0] w_sum_nxt;
    logic [LO+SW-1:0] r_sum;
    logic             r_c, r_z;

    if (k == 0) begin : g_src
      assign w_asrc    = i_a;
      assign w_bsrc    = w_effb;
      assign w_ci      = w_effc;
      assign w_zi      = 1'b1;
      assign w_sum_nxt = w_ss;
    end else begin : g_src
      assign w_asrc    = g_stg[k-1].g_skew.r_ahi;
      assign w_bsrc    = g_stg[k-1].g_skew.r_bhi;
      assign w_ci      = g_stg[k-1].r_c;
      assign w_zi      = g_stg[k-1].r_z;
      assign w_sum_nxt = {w_ss, g_stg[k-1].r_sum};
    end

    alu_addsub_cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
      .i_a (w_asrc[SW-1:0]),
      .i_b (w_bsrc[SW-1:0]),
      .i_c (w_ci),
      .o_s (w_ss),
      .o_c (w_co)
    );

    // slice result, carry to the next slice, and running zero flag
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_sum <= '0;
        r_c   <= 1'b0;
        r_z   <= 1'b0;
      end else if (w_adv) begin
        r_sum <= w_sum_nxt;
        r_c   <= w_co;
        r_z   <= w_zi & (w_ss == '0);
      end
    end

    if (k < STAGES-1) begin : g_skew
      logic [REM-SW-1:0] r_ahi, r_bhi;
      // forward the operand bits that later slices still need
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_ahi <= '0;
          r_bhi <= '0;
        end else if (w_adv) begin
          r_ahi <= w_asrc[REM-1:SW];
          r_bhi <= w_bsrc[REM-1:SW];
        end
      end
    end else begin : g_fin
      logic r_ovf;
      // signed overflow: operands agree in sign, result does not
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_ovf <= 1'b0;
        else if (w_adv)
          r_ovf <= (w_asrc[SW-1] == w_bsrc[SW-1]) && (w_ss[SW-1] != w_asrc[SW-1]);
      end
    end
  end

  assign o_in_ready  = w_adv;
  assign o_out_valid = r_vld_pipe[STAGES-1];
  assign o_sum       = g_stg[STAGES-1].r_sum;
  assign o_cout      = g_stg[STAGES-1].r_c;
  assign o_zero      = g_stg[STAGES-1].r_z;
  assign o_ovf       = g_stg[STAGES-1].g_fin.r_ovf;
  assign o_neg       = g_stg[STAGES-1].r_sum[WIDTH-1];
endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Directed bench for alu_addsub_pipe (WIDTH=16, STAGES=2).
module tb_alu_addsub_pipe;
  localparam int W   = 16;
  localparam int STG = 2;

  logic         i_clk = 0, i_rst = 1;
  logic         i_in_valid = 0, i_out_ready = 1;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         i_sub = 0, i_use_cin = 0, i_cin = 0;
  logic         o_in_ready, o_out_valid, o_cout, o_ovf, o_zero, o_neg;
  logic [W-1:0] o_sum;

  int n_tests = 0, n_fail = 0;

  alu_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(STG)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_use_cin(i_use_cin), .i_cin(i_cin),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_sum(o_sum),
    .o_cout(o_cout), .o_ovf(o_ovf), .o_zero(o_zero), .o_neg(o_neg)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated beat: measure latency and check every output field.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic uc, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input logic ez, input logic en);
    int n;
    @(posedge i_clk); #1;
    i_a = a; i_b = b; i_sub = sub; i_use_cin = uc; i_cin = cin;
    i_out_ready = 1; i_in_valid = 1;
    @(posedge i_clk); #1;
    i_in_valid = 0;
    n = 1;
    while (!o_out_valid && n < 10) begin @(posedge i_clk); #1; n++; end
    chk({tag, "_lat"},  n, STG);
    chk({tag, "_sum"},  o_sum, es);
    chk({tag, "_cout"}, o_cout, ec);
    chk({tag, "_ovf"},  o_ovf, eo);
    chk({tag, "_zero"}, o_zero, ez);
    chk({tag, "_neg"},  o_neg, en);
  endtask

  // backpressure stream vectors
  logic [W-1:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h00FF, 16'hA5A5, 16'h7FFF, 16'h0000};
  logic [W-1:0] vb [8] = '{16'h4321, 16'h0001, 16'h8000, 16'hF0F1, 16'h0001, 16'h5A5A, 16'hFFFF, 16'h0000};
  logic         vs [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic         vu [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  logic         vc [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
  logic [15:0]  rdy_pat = 16'b1011_0010_1101_0110;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic uc, input logic cin);
    logic [W-1:0] eb;
    logic         ec;
    eb = sub ? ~b : b;
    ec = uc ? cin : sub;
    return {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, ec};
  endfunction

  initial begin
    logic [W:0]  q[$];
    logic [19:0] held;
    logic        stalled, need_new;
    int          sent, got, cyc, stale, idx;

    // reset state
    #1;
    chk("rst_vld",   o_out_valid, 0);
    chk("rst_rdy",   o_in_ready, 1);
    chk("rst_sum",   o_sum, 0);
    chk("rst_flags", {o_cout, o_ovf, o_zero, o_neg}, 0);
    @(negedge i_clk); i_rst = 0;

    run_op("add_ovf",  16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1, 0, 1);
    run_op("wrap0",    16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 1, 0);
    run_op("sub_eq",   16'h0005, 16'h0005, 1, 0, 0, 16'h0000, 1, 0, 1, 0);
    run_op("sub_neg",  16'h0003, 16'h0005, 1, 0, 0, 16'hFFFE, 0, 0, 0, 1);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1, 0, 0, 16'h7FFF, 1, 1, 0, 0);
    run_op("adc",      16'h1234, 16'h0001, 0, 1, 1, 16'h1236, 0, 0, 0, 0);
    run_op("sbc",      16'h0010, 16'h0001, 1, 1, 0, 16'h000E, 1, 0, 0, 0);

    // backpressure stream
    sent = 0; got = 0; cyc = 0; stalled = 0; need_new = 1; held = '0; idx = 0;
    while (got < 8 && cyc < 300) begin
      @(posedge i_clk); #1;
      i_out_ready = rdy_pat[cyc % 16];
      cyc++;
      if (need_new) begin
        if (sent < 8) begin
          idx = sent;
          i_a = va[idx]; i_b = vb[idx]; i_sub = vs[idx]; i_use_cin = vu[idx]; i_cin = vc[idx];
          i_in_valid = 1;
        end else i_in_valid = 0;
        need_new = 0;
      end
      @(negedge i_clk);
      if (stalled) begin
        chk("bp_hold_vld", o_out_valid, 1);
        chk("bp_hold_dat", {o_ovf, o_zero, o_neg, o_cout, o_sum}, held);
      end
      chk("bp_ready", o_in_ready, !(o_out_valid && !i_out_ready));
      if (o_out_valid && i_out_ready) begin
        chk("bp_qsize", q.size() > 0, 1);
        if (q.size() > 0) chk("bp_res", {o_cout, o_sum}, q.pop_front());
        got++;
      end
      if (i_in_valid && o_in_ready) begin
        q.push_back(model(i_a, i_b, i_sub, i_use_cin, i_cin));
        sent++;
        need_new = 1;
      end
      stalled = o_out_valid && !i_out_ready;
      held = {o_ovf, o_zero, o_neg, o_cout, o_sum};
    end
    chk("bp_count", got, 8);
    chk("bp_sent", sent, 8);
    @(posedge i_clk); #1;
    i_in_valid = 0; i_out_ready = 1;

    // reset mid-stream
    @(posedge i_clk); #1;
    i_a = 16'h0001; i_b = 16'h0002; i_sub = 0; i_use_cin = 0; i_in_valid = 1;
    @(posedge i_clk); #1;
    i_a = 16'h0003; i_b = 16'h0004;
    @(posedge i_clk); #3;
    i_in_valid = 0; i_rst = 1;
    #1;
    chk("mid_rst_vld",   o_out_valid, 0);
    chk("mid_rst_rdy",   o_in_ready, 1);
    chk("mid_rst_sum",   o_sum, 0);
    chk("mid_rst_flags", {o_cout, o_ovf, o_zero, o_neg}, 0);
    @(negedge i_clk); i_rst = 0;
    stale = 0;
    repeat (4) begin @(negedge i_clk); if (o_out_valid) stale++; end
    chk("mid_rst_stale", stale, 0);
    run_op("post_rst", 16'h0001, 16'h0001, 0, 0, 0, 16'h0002, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It generalises the fixed 16-bit lookahead adder to any width, with selectable add, subtract and add-with-carry modes, and produces carry, overflow, zero and negative flags. The operand width is split into STAGES register slices, each a block-lookahead adder, with a registered carry passed between slices. The block has valid/ready handshakes on both sides, so it sits between the operand-fetch stage and writeback with full backpressure.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
GROUP, 4, lookahead group size inside each slice; (WIDTH/STAGES) must be a multiple of GROUP.
STAGES, 2, pipeline depth and number of carry slices; legal range 1..4.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
sub  in  1  1 = A - B (two's complement), 0 = A + B
use_cin  in  1  1 = carry-in taken from cin (ADC/SBC chaining)
cin  in  1  external carry-in; for subtract, 1 means no borrow
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
sum  out  WIDTH  result
cout  out  1  carry out of the MSB; for subtract, 1 means no borrow
ovf  out  1  signed overflow
zero  out  1  sum == 0
neg  out  1  sum[WIDTH-1]

Behaviour:
- Operation:
  - Effective B is b XOR {WIDTH{sub}}.
  - Effective carry-in is cin when use_cin = 1; otherwise it equals sub.
  - Result is {cout, sum} = a + effB + effCin, computed modulo 2^(WIDTH+1).
- ovf = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
- Slices:
  - Stage k adds bits [k*W/S +: W/S], using the registered carry from stage k-1.
  - Stage 0 uses effCin.
  - Upper operand bits are carried forward in skew registers.
  - Lower result bits are carried forward in deskew registers.
  - A running zero flag (AND of slice-zero) is carried with the data.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 1, every stage shifts by one. Stage 0 loads the input beat, and its valid bit = in_valid.
  - When advance = 0, all stage registers and valid bits hold.
  - A beat is accepted iff in_valid && in_ready.
  - A result is consumed iff out_valid && out_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure. Throughput is one beat per cycle.
- Outputs are registered and stay stable while out_valid && !out_ready.
- Ordering: results emerge in acceptance order; no beat is dropped or duplicated.
- Bubbles: invalid stages still shift when advance = 1, so bubbles collapse only at the output.
- in_ready depends only on out_valid and out_ready; it has no combinational path from in_valid.
- Reset:
  - Asynchronous assertion clears all valid bits: out_valid = 0, in_ready = 1 (since out_valid = 0).
  - sum = 0, cout = 0, ovf = 0, zero = 0, neg = 0.
  - Data registers may also clear.
  - Reset mid-stream discards every in-flight beat.
  - The first beat after deassertion is accepted on the first rising edge with in_valid = 1.
- STAGES = 1: a single registered lookahead adder with latency 1.

Test Plan:
1. Add overflow (WIDTH=16, STAGES=2): a=0x7FFF, b=0x0001, sub=0, use_cin=0 -> after 2 cycles sum=0x8000, cout=0, ovf=1, neg=1, zero=0.
2. Wrap to zero: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0, zero=1, neg=0. Also checks the cross-slice carry from bit 7 into bit 8.
3. Subtract: a=0x0005, b=0x0005, sub=1 -> sum=0x0000, cout=1, zero=1. Then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, neg=1, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
4. Carry chaining: use_cin=1, cin=1, a=0x1234, b=0x0001, add -> sum=0x1236. Then use_cin=1, cin=0, sub=1, a=0x0010, b=0x0001 -> sum=0x000E.
5. Backpressure stream: issue 8 back-to-back random beats with out_ready toggled pseudo-randomly -> scoreboard sees all 8 results in order with correct values. Outputs hold while stalled; in_ready=0 exactly when out_valid=1 and out_ready=0.
6. Reset mid-operation: accept 2 beats, then assert rst asynchronously between edges -> out_valid=0, all flag outputs 0 and in_ready=1 immediately. After release, no stale result appears, and a new beat (0x0001+0x0001) yields 0x0002 after 2 cycles.
